// File: rtl/tuart_rx.sv
// UART receiver: 2-FF synchronised rx line, mid-bit sampling, framing-error
// detection with break suppression, optional XON/XOFF consumption.
module tuart_rx #(
  parameter int unsigned WORD_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter bit          XONXOFF_EN   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 rx_i,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 xoff_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BITS - 1);
  localparam bit FC_EN = XONXOFF_EN && (WORD_BITS == 8);
  localparam logic [WORD_BITS-1:0] XON_W  = WORD_BITS'(8'h11);
  localparam logic [WORD_BITS-1:0] XOFF_W = WORD_BITS'(8'h13);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 xoff_q, xoff_d;
  logic                 rx_s;

  assign rx_s = sync_q[1];

  // Next-state logic for synchroniser, bit timing FSM and registered outputs
  always_comb begin
    sync_d  = {sync_q[0], rx_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    xoff_d  = xoff_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + IW'(1);
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Leave at mid stop bit so a start edge right after one stop bit is caught.
          if (rx_s) begin
            state_d = S_IDLE;
            if (FC_EN && shift_q == XOFF_W)     xoff_d = 1'b1;
            else if (FC_EN && shift_q == XON_W) xoff_d = 1'b0;
            else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      xoff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      xoff_q  <= xoff_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign xoff_o      = xoff_q;

endmodule

// File: tb/tb_tuart_rx.sv
// Scoreboard bench for tuart_rx: two instances (flow control on/off) share one rx line.
module tb_tuart_rx;

  localparam int unsigned CPB = 16;
  // Output appears 3 cycles after the stop-bit midpoint (9.5 bit times after the start edge).
  localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  logic [7:0] fc_data, raw_data;
  logic       fc_valid, raw_valid, fc_ferr, raw_ferr, fc_xoff, raw_xoff;

  tuart_rx #(.WORD_BITS(8), .CLKS_PER_BIT(CPB), .XONXOFF_EN(1'b1)) u_fc (
    .clk_i(clk), .rst_in(rst_n), .rx_i(rx),
    .data_o(fc_data), .valid_o(fc_valid), .frame_err_o(fc_ferr), .xoff_o(fc_xoff)
  );

  tuart_rx #(.WORD_BITS(8), .CLKS_PER_BIT(CPB), .XONXOFF_EN(1'b0)) u_raw (
    .clk_i(clk), .rst_in(rst_n), .rx_i(rx),
    .data_o(raw_data), .valid_o(raw_valid), .frame_err_o(raw_ferr), .xoff_o(raw_xoff)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    logic [31:0] at;
  } exp_t;

  exp_t q_fc[$];
  exp_t q_raw[$];
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  bit model_xoff = 1'b0;
  logic [7:0] last_fc = '0;
  logic [7:0] last_raw = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pop the expected event for one instance and compare kind, data and arrival cycle
  task automatic mon(input int inst, input logic v, input logic e, input logic [7:0] d);
    exp_t x;
    bit have;
    string tag;
    tag = (inst == 0) ? "fc" : "raw";
    if (v || e) begin
      chk({tag, "_valid_ferr_exclusive"}, {31'd0, v & e}, 32'd0);
      have = (inst == 0) ? (q_fc.size() > 0) : (q_raw.size() > 0);
      chk({tag, "_output_expected"}, {31'd0, have}, 32'd1);
      if (have) begin
        x = (inst == 0) ? q_fc.pop_front() : q_raw.pop_front();
        chk({tag, "_event_kind_is_err"}, {31'd0, e}, {31'd0, x.is_err});
        if (!x.is_err) chk({tag, "_data"}, {24'd0, d}, {24'd0, x.data});
        chk({tag, "_arrival_cycle"}, cyc, x.at);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, fc_valid, fc_ferr, fc_data);
      mon(1, raw_valid, raw_ferr, raw_data);
    end
  end

  // All driver tasks start and end at posedge+1
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned hold_bits);
    exp_t e;
    bit is_fc;
    is_fc    = (b == 8'h11) || (b == 8'h13);
    e.at     = cyc + LAT;
    e.is_err = !stop_ok;
    e.data   = b;
    q_raw.push_back(e);
    if (!stop_ok || !is_fc) q_fc.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) begin
      repeat (hold_bits * CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (stop_ok) begin
      last_raw = b;
      if (b == 8'h13) model_xoff = 1'b1;
      else if (b == 8'h11) model_xoff = 1'b0;
      else last_fc = b;
    end
    chk("fc_xoff", {31'd0, fc_xoff}, {31'd0, model_xoff});
    chk("raw_xoff", {31'd0, raw_xoff}, 32'd0);
  endtask

  task automatic chk_outputs(input string name);
    chk({name, "_fc_data"}, {24'd0, fc_data}, {24'd0, last_fc});
    chk({name, "_raw_data"}, {24'd0, raw_data}, {24'd0, last_raw});
    chk({name, "_fc_valid"}, {31'd0, fc_valid}, 32'd0);
    chk({name, "_raw_valid"}, {31'd0, raw_valid}, 32'd0);
    chk({name, "_fc_ferr"}, {31'd0, fc_ferr}, 32'd0);
    chk({name, "_raw_ferr"}, {31'd0, raw_ferr}, 32'd0);
    chk({name, "_fc_xoff"}, {31'd0, fc_xoff}, {31'd0, model_xoff});
    chk({name, "_raw_xoff"}, {31'd0, raw_xoff}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit ok;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs("reset");
    rst_n = 1'b1;
    idle(2 * CPB);

    // Single frame, then back-to-back frames with one stop bit
    send_frame(8'hA5, 1'b1, 0);
    idle(CPB);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(CPB);

    // Short low glitch is rejected, next frame decodes
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    idle(3 * CPB);
    chk_outputs("after_glitch");
    send_frame(8'h5A, 1'b1, 0);
    idle(CPB);

    // Bad stop bit followed by a long break: one error, data held
    send_frame(8'h3C, 1'b0, 40);
    idle(2 * CPB);
    chk_outputs("after_break");
    send_frame(8'h42, 1'b1, 0);
    idle(CPB);

    // Flow-control characters
    send_frame(8'h13, 1'b1, 0);
    idle(CPB);
    send_frame(8'h11, 1'b1, 0);
    idle(CPB);

    // Randomised frames with occasional flow-control bytes and bad stop bits
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'h13;
        1:       b = 8'h11;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ok = ($urandom_range(0, 6) != 0);
      send_frame(b, ok, ok ? 0 : $urandom_range(0, 3));
      if (!ok || $urandom_range(0, 1) == 1)
        idle((ok ? 0 : CPB) + $urandom_range(1, 2 * CPB));
    end
    idle(CPB);

    // Reset in the middle of data bit 4 of a frame
    send_frame(8'h13, 1'b1, 0);
    send_frame(8'h7E, 1'b1, 0);
    idle(CPB);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    model_xoff = 1'b0;
    last_fc    = '0;
    last_raw   = '0;
    chk_outputs("mid_frame_reset");
    rx = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    rst_n = 1'b1;
    idle(2 * CPB);
    chk_outputs("after_reset_release");
    send_frame(8'hC3, 1'b1, 0);
    idle(3 * CPB);

    chk("fc_queue_drained", q_fc.size(), 32'd0);
    chk("raw_queue_drained", q_raw.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
